// File: rtl/neighbor_write_ctrl_pkg.sv
// Shared definitions for the neighbour-table write path: packet type codes,
// controller states and the default node identity.
package neighbor_pkg;

    localparam logic [2:0] MEMREQ = 3'd2;
    localparam logic [2:0] DATA   = 3'd3;
    localparam logic [2:0] SOS    = 3'd4;

    localparam logic [15:0] MY_NODE_ID_DEFAULT = 16'h000C;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        SCAN,
        WRITE,
        HOLD
    } ctrl_state_e;

    // Only these packet kinds carry neighbour information worth recording.
    function automatic logic is_tracked_type(input logic [2:0] pkt_type);
        return (pkt_type == MEMREQ) || (pkt_type == DATA) || (pkt_type == SOS);
    endfunction

endpackage

// File: rtl/neighbor_write_ctrl_if.sv
// Bundle between the packet parser / neighbour table and the write controller.
// The controller is the slave side; the parser/table environment is the master side.
interface neighbor_write_ctrl_if #(
    parameter int WORD_WIDTH = 16,
    parameter int IDX_W      = 5
);
    logic                  pkt_valid;
    logic                  pkt_ready;
    logic [2:0]            pkt_type;
    logic [WORD_WIDTH-1:0] pkt_src_id;
    logic [WORD_WIDTH-1:0] pkt_hops;
    logic [WORD_WIDTH-1:0] pkt_qvalue;
    logic [WORD_WIDTH-1:0] pkt_energy;
    logic [WORD_WIDTH-1:0] pkt_chosen_ch;
    logic [WORD_WIDTH-1:0] pkt_ch_hops;
    logic [WORD_WIDTH-1:0] my_chosen_ch;
    logic                  hb_reset_in;

    logic                  wr_en;
    logic [WORD_WIDTH-1:0] nodeID;
    logic [WORD_WIDTH-1:0] nodeHops;
    logic [WORD_WIDTH-1:0] nodeQValue;
    logic [WORD_WIDTH-1:0] nodeEnergy;
    logic [WORD_WIDTH-1:0] chosenCH;
    logic [WORD_WIDTH-1:0] nodeCHHops;
    logic [WORD_WIDTH-1:0] neighborCount;
    logic                  HB_reset;
    logic [IDX_W:0]        entry_count;
    logic                  table_full;
    logic                  drop_pulse;

    modport master (
        output pkt_valid, pkt_type, pkt_src_id, pkt_hops, pkt_qvalue, pkt_energy,
               pkt_chosen_ch, pkt_ch_hops, my_chosen_ch, hb_reset_in,
        input  pkt_ready, wr_en, nodeID, nodeHops, nodeQValue, nodeEnergy, chosenCH,
               nodeCHHops, neighborCount, HB_reset, entry_count, table_full, drop_pulse
    );

    modport slave (
        input  pkt_valid, pkt_type, pkt_src_id, pkt_hops, pkt_qvalue, pkt_energy,
               pkt_chosen_ch, pkt_ch_hops, my_chosen_ch, hb_reset_in,
        output pkt_ready, wr_en, nodeID, nodeHops, nodeQValue, nodeEnergy, chosenCH,
               nodeCHHops, neighborCount, HB_reset, entry_count, table_full, drop_pulse
    );

endinterface

// File: rtl/neighbor_write_ctrl_id_cam.sv
// Shadow copy of the neighbour IDs held in the table: an indexed ID store with
// per-slot valid bits, append-at-end and a bulk clear.
module neighbor_id_cam #(
    parameter int WORD_WIDTH  = 16,
    parameter int TABLE_DEPTH = 32,
    parameter int IDX_W       = 5
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic [IDX_W-1:0]      rd_idx_i,
    output logic [WORD_WIDTH-1:0] rd_id_o,
    output logic                  rd_valid_o,
    input  logic                  append_i,
    input  logic [WORD_WIDTH-1:0] append_id_i,
    input  logic                  clear_i,
    output logic [IDX_W:0]        count_o
);

    localparam logic [IDX_W:0] DEPTH_C = (IDX_W+1)'(TABLE_DEPTH);

    logic [WORD_WIDTH-1:0]  id_q [TABLE_DEPTH];
    logic [TABLE_DEPTH-1:0] valid_q;
    logic [IDX_W:0]         count_q;
    logic                   append_ok;

    assign append_ok = append_i && !clear_i && (count_q != DEPTH_C);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            valid_q <= '0;
            count_q <= '0;
        end else if (clear_i) begin
            valid_q <= '0;
            count_q <= '0;
        end else if (append_ok) begin
            valid_q[count_q[IDX_W-1:0]] <= 1'b1;
            count_q                     <= count_q + 1'b1;
        end
    end

    // ID payload needs no reset: a slot is only trusted once its valid bit is set.
    always_ff @(posedge clk) begin
        if (append_ok) begin
            id_q[count_q[IDX_W-1:0]] <= append_id_i;
        end
    end

    assign rd_id_o    = id_q[rd_idx_i];
    assign rd_valid_o = valid_q[rd_idx_i];
    assign count_o    = count_q;

endmodule

// File: rtl/neighbor_write_ctrl.sv
// Neighbour-table write controller: filters overheard packets, resolves the
// slot against the shadow ID list and drives the table's write port.
module neighbor_write_ctrl
    import neighbor_pkg::*;
#(
    parameter int                    WORD_WIDTH  = 16,
    parameter int                    TABLE_DEPTH = 32,
    parameter int                    IDX_W       = 5,
    parameter logic [WORD_WIDTH-1:0] MY_NODE_ID  = MY_NODE_ID_DEFAULT
) (
    input logic                  clk,
    input logic                  nrst,
    neighbor_write_ctrl_if.slave bus_io
);

    localparam logic [IDX_W:0] DEPTH_C = (IDX_W+1)'(TABLE_DEPTH);

    ctrl_state_e           state_q, state_d;
    logic [WORD_WIDTH-1:0] src_q, hops_q, qval_q, energy_q, ch_q, chhops_q;
    logic                  pass_q;
    logic [IDX_W-1:0]      scan_idx_q;
    logic [IDX_W-1:0]      slot_q, slot_d;
    logic                  hb_pend_q, ready_q, wr_en_q, hb_reset_q, drop_q, drop_d;
    logic [WORD_WIDTH-1:0] node_id_q, node_hops_q, node_qval_q, node_energy_q;
    logic [WORD_WIDTH-1:0] node_ch_q, node_chhops_q;

    logic                  transfer, pass_now, hb_req, hb_fire;
    logic                  do_write, cam_append, hit, last_entry;
    logic [WORD_WIDTH-1:0] cam_rd_id;
    logic                  cam_rd_valid;
    logic [IDX_W:0]        cam_count;

    neighbor_id_cam #(
        .WORD_WIDTH (WORD_WIDTH),
        .TABLE_DEPTH(TABLE_DEPTH),
        .IDX_W      (IDX_W)
    ) u_cam (
        .clk        (clk),
        .nrst       (nrst),
        .rd_idx_i   (scan_idx_q),
        .rd_id_o    (cam_rd_id),
        .rd_valid_o (cam_rd_valid),
        .append_i   (cam_append),
        .append_id_i(src_q),
        .clear_i    (hb_fire),
        .count_o    (cam_count)
    );

    assign transfer   = bus_io.pkt_valid && bus_io.pkt_ready;
    assign pass_now   = is_tracked_type(bus_io.pkt_type)
                     && (bus_io.pkt_chosen_ch == bus_io.my_chosen_ch)
                     && (bus_io.my_chosen_ch != '0)
                     && (bus_io.pkt_src_id != MY_NODE_ID);
    assign hb_req     = bus_io.hb_reset_in || hb_pend_q;
    assign hit        = cam_rd_valid && (cam_rd_id == src_q);
    assign last_entry = ({1'b0, scan_idx_q} == (cam_count - 1'b1));

    // A heartbeat reset is only ever issued on an edge that lands in IDLE, so it
    // can never collide with an append into the shadow list.
    always_comb begin
        state_d    = state_q;
        slot_d     = slot_q;
        do_write   = 1'b0;
        cam_append = 1'b0;
        drop_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (transfer) begin
                    state_d = CHECK;
                    drop_d  = !pass_now;
                end
            end
            CHECK: begin
                if (!pass_q) begin
                    state_d = IDLE;
                end else if (cam_count == '0) begin
                    state_d    = WRITE;
                    do_write   = 1'b1;
                    cam_append = 1'b1;
                    slot_d     = '0;
                end else begin
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (hit) begin
                    state_d  = WRITE;
                    do_write = 1'b1;
                    slot_d   = scan_idx_q;
                end else if (last_entry) begin
                    if (cam_count == DEPTH_C) begin
                        state_d = IDLE;
                        drop_d  = 1'b1;
                    end else begin
                        state_d    = WRITE;
                        do_write   = 1'b1;
                        cam_append = 1'b1;
                        slot_d     = cam_count[IDX_W-1:0];
                    end
                end
            end
            WRITE:   state_d = HOLD;
            HOLD:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        hb_fire = hb_req && (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q       <= IDLE;
            src_q         <= '0;
            hops_q        <= '0;
            qval_q        <= '0;
            energy_q      <= '0;
            ch_q          <= '0;
            chhops_q      <= '0;
            pass_q        <= 1'b0;
            scan_idx_q    <= '0;
            slot_q        <= '0;
            hb_pend_q     <= 1'b0;
            ready_q       <= 1'b0;
            wr_en_q       <= 1'b0;
            hb_reset_q    <= 1'b0;
            drop_q        <= 1'b0;
            node_id_q     <= '0;
            node_hops_q   <= '0;
            node_qval_q   <= '0;
            node_energy_q <= '0;
            node_ch_q     <= '0;
            node_chhops_q <= '0;
        end else begin
            state_q    <= state_d;
            wr_en_q    <= do_write;
            drop_q     <= drop_d;
            hb_reset_q <= hb_fire;
            hb_pend_q  <= hb_req && !hb_fire;
            ready_q    <= (state_d == IDLE) && !hb_fire;
            if (transfer) begin
                src_q    <= bus_io.pkt_src_id;
                hops_q   <= bus_io.pkt_hops;
                qval_q   <= bus_io.pkt_qvalue;
                energy_q <= bus_io.pkt_energy;
                ch_q     <= bus_io.pkt_chosen_ch;
                chhops_q <= bus_io.pkt_ch_hops;
                pass_q   <= pass_now;
            end
            if (state_q == CHECK) begin
                scan_idx_q <= '0;
            end else if (state_q == SCAN) begin
                scan_idx_q <= scan_idx_q + 1'b1;
            end
            // Write data stays frozen through HOLD and beyond, since the table
            // samples it one cycle after the strobe.
            if (do_write) begin
                slot_q        <= slot_d;
                node_id_q     <= src_q;
                node_hops_q   <= hops_q;
                node_qval_q   <= qval_q;
                node_energy_q <= energy_q;
                node_ch_q     <= ch_q;
                node_chhops_q <= chhops_q;
            end
        end
    end

    assign bus_io.pkt_ready     = ready_q && !bus_io.hb_reset_in;
    assign bus_io.wr_en         = wr_en_q;
    assign bus_io.nodeID        = node_id_q;
    assign bus_io.nodeHops      = node_hops_q;
    assign bus_io.nodeQValue    = node_qval_q;
    assign bus_io.nodeEnergy    = node_energy_q;
    assign bus_io.chosenCH      = node_ch_q;
    assign bus_io.nodeCHHops    = node_chhops_q;
    assign bus_io.neighborCount = {{(WORD_WIDTH-IDX_W){1'b0}}, slot_q};
    assign bus_io.HB_reset      = hb_reset_q;
    assign bus_io.entry_count   = cam_count;
    assign bus_io.table_full    = (cam_count == DEPTH_C);
    assign bus_io.drop_pulse    = drop_q;

endmodule
